// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for load-use, taken-branch and multi-cycle mul/div hazards
// Optional HAZARD_STALL_STATS_EN adds saturating StallCount/FlushCount outputs.
module pipeline_hazard_controller #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] IFID_Rs,
    input  logic [4:0] IFID_Rt,
    input  logic       IFID_UsesRt,
    input  logic [4:0] IDEX_Rt,
    input  logic       IDEX_MemRead,
    input  logic       IDEX_MulDivStart,
    input  logic       BranchTaken,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IFID_Flush,
    output logic       IDEXWrite,
    output logic       IDEX_Bubble,
    output logic       EXMEM_Bubble,
    output logic       MulDivBusy,
    output logic       MulDivDone
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
`endif
);
    typedef enum logic {RUN, MD_BUSY} state_t;
    localparam logic [CNT_W-1:0] MD_INIT = CNT_W'((MD_LATENCY > 1) ? MD_LATENCY - 2 : 0);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic lu;
    assign lu = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
    // State and countdown register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // Next state and pipeline controls; mul/div freeze holds IF/ID/EX while EX/MEM takes bubbles
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
        IDEXWrite    = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Bubble  = 1'b0;
        EXMEM_Bubble = 1'b0;
        MulDivBusy   = 1'b0;
        MulDivDone   = 1'b0;
        if (!rst_n) begin
            state_nx = RUN;
            cnt_nx   = '0;
        end else if (state == RUN) begin
            if (BranchTaken) begin
                IFID_Flush  = 1'b1;
                IDEX_Bubble = 1'b1;
            end else if (IDEX_MulDivStart) begin
                if (MD_LATENCY == 1) begin
                    MulDivDone = 1'b1;
                end else begin
                    PCWrite      = 1'b0;
                    IFIDWrite    = 1'b0;
                    IDEXWrite    = 1'b0;
                    EXMEM_Bubble = 1'b1;
                    state_nx     = MD_BUSY;
                    cnt_nx       = MD_INIT;
                end
            end else if (lu) begin
                PCWrite     = 1'b0;
                IFIDWrite   = 1'b0;
                IDEX_Bubble = 1'b1;
            end
        end else begin
            MulDivBusy = 1'b1;
            if (cnt != '0) begin
                PCWrite      = 1'b0;
                IFIDWrite    = 1'b0;
                IDEXWrite    = 1'b0;
                EXMEM_Bubble = 1'b1;
                cnt_nx       = cnt - CNT_W'(1);
            end else begin
                MulDivDone = 1'b1;
                state_nx   = RUN;
            end
        end
    end
`ifdef HAZARD_STALL_STATS_EN
    // Saturating stall and flush event counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (!PCWrite && StallCount != 32'hFFFF_FFFF) StallCount <= StallCount + 32'd1;
            if (IFID_Flush && FlushCount != 32'hFFFF_FFFF) FlushCount <= FlushCount + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: vector table, mul/div/reset sequences and randomized model check
module tb_pipeline_hazard_controller;
    localparam int L = 4;
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [4:0] ex_rt;
        logic       memread;
        logic       mdstart;
        logic       branch;
        logic       rst_n;
    } in_t;
    typedef struct {
        in_t        i;
        logic [7:0] exp;
        string      name;
    } vec_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [4:0] IFID_Rs = '0, IFID_Rt = '0, IDEX_Rt = '0;
    logic IFID_UsesRt = 1'b0, IDEX_MemRead = 1'b0, IDEX_MulDivStart = 1'b0, BranchTaken = 1'b0;
    logic PCWrite, IFIDWrite, IFID_Flush, IDEXWrite, IDEX_Bubble, EXMEM_Bubble, MulDivBusy, MulDivDone;
`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] StallCount, FlushCount;
`endif
    int tests = 0, fails = 0;
    int md_age = 0;
    int unsigned m_stall = 0, m_flush = 0;
    vec_t vt[9];

    pipeline_hazard_controller #(.MD_LATENCY(L), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .IDEX_Rt(IDEX_Rt), .IDEX_MemRead(IDEX_MemRead), .IDEX_MulDivStart(IDEX_MulDivStart),
        .BranchTaken(BranchTaken), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFID_Flush(IFID_Flush),
        .IDEXWrite(IDEXWrite), .IDEX_Bubble(IDEX_Bubble), .EXMEM_Bubble(EXMEM_Bubble),
        .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone)
`ifdef HAZARD_STALL_STATS_EN
        , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
    );

    always #5 clk = ~clk;

    function automatic in_t mk(int rs, int rt, bit uses, int ex_rt, bit mem, bit md, bit br, bit rn = 1'b1);
        in_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = uses; v.ex_rt = 5'(ex_rt);
        v.memread = mem; v.mdstart = md; v.branch = br; v.rst_n = rn;
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {PCWrite, IFIDWrite, IFID_Flush, IDEXWrite, IDEX_Bubble, EXMEM_Bubble, MulDivBusy, MulDivDone};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    // apply inputs half a cycle away from the rising edge
    task automatic apply(in_t v);
        @(negedge clk);
        rst_n = v.rst_n; IFID_Rs = v.rs; IFID_Rt = v.rt; IFID_UsesRt = v.uses_rt; IDEX_Rt = v.ex_rt;
        IDEX_MemRead = v.memread; IDEX_MulDivStart = v.mdstart; BranchTaken = v.branch;
        #1;
    endtask

    task automatic step(in_t v, logic [7:0] exp, string name);
        apply(v);
        check(name, 32'(outs()), 32'(exp));
    endtask

    // reference: md_age is the position within a mul/div operation (0 = none, start cycle is age 1)
    function automatic logic [7:0] model_out(in_t v);
        logic pc, ifw, fl, idw, idb, exb, busy, done;
        bit lu;
        lu = v.memread && v.ex_rt != 0 && (v.ex_rt == v.rs || (v.uses_rt && v.ex_rt == v.rt));
        {pc, ifw, fl, idw, idb, exb, busy, done} = 8'b1101_0000;
        if (v.rst_n) begin
            if (md_age >= 2) begin
                busy = 1;
                if (md_age < L) {pc, ifw, idw, exb} = 4'b0001;
                else done = 1;
            end else if (v.branch) begin
                fl = 1; idb = 1;
            end else if (v.mdstart) begin
                if (L == 1) done = 1;
                else {pc, ifw, idw, exb} = 4'b0001;
            end else if (lu) begin
                pc = 0; ifw = 0; idb = 1;
            end
        end
        return {pc, ifw, fl, idw, idb, exb, busy, done};
    endfunction

    task automatic model_adv(in_t v, logic [7:0] o);
        if (!v.rst_n) begin
            md_age = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!o[7] && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (o[5] && m_flush != 32'hFFFF_FFFF) m_flush++;
            if (md_age >= 2) md_age = (md_age < L) ? md_age + 1 : 0;
            else if (!v.branch && v.mdstart && L > 1) md_age = 2;
        end
    endtask

    initial begin
        vt[0] = '{mk(8, 0, 0, 8, 1, 0, 0), 8'b0001_1000, "lu_rs"};
        vt[1] = '{mk(3, 0, 0, 8, 0, 0, 0), 8'b1101_0000, "lu_clears"};
        vt[2] = '{mk(0, 0, 1, 0, 1, 0, 0), 8'b1101_0000, "lu_r0"};
        vt[3] = '{mk(1, 9, 0, 9, 1, 0, 0), 8'b1101_0000, "rt_unused"};
        vt[4] = '{mk(1, 9, 1, 9, 1, 0, 0), 8'b0001_1000, "rt_used"};
        vt[5] = '{mk(8, 0, 0, 8, 1, 0, 1), 8'b1111_1000, "branch_over_lu"};
        vt[6] = '{mk(2, 0, 0, 5, 0, 1, 1), 8'b1111_1000, "branch_wins_md"};
        vt[7] = '{mk(8, 0, 0, 8, 0, 0, 0), 8'b1101_0000, "no_memread"};
        vt[8] = '{mk(4, 6, 1, 7, 1, 0, 0), 8'b1101_0000, "no_match"};
        step(mk(0, 0, 0, 0, 0, 0, 0, 0), 8'b1101_0000, "in_reset");
        step(mk(0, 0, 0, 0, 0, 0, 0), 8'b1101_0000, "after_reset");
        foreach (vt[k]) step(vt[k].i, vt[k].exp, vt[k].name);
        // mul/div held in EX with branch and load-use arriving while busy
        step(mk(0, 0, 0, 0, 0, 1, 0), 8'b0000_0100, "md_c1");
        step(mk(8, 0, 0, 8, 1, 1, 1), 8'b0000_0110, "md_c2_ignore");
        step(mk(8, 0, 0, 8, 1, 1, 1), 8'b0000_0110, "md_c3_ignore");
        step(mk(0, 0, 0, 0, 0, 1, 0), 8'b1101_0011, "md_c4_done");
        step(mk(0, 0, 0, 0, 0, 1, 0), 8'b0000_0100, "md_b2b_start");
        step(mk(0, 0, 0, 0, 0, 1, 0, 0), 8'b1101_0000, "md_reset_c2");
        step(mk(0, 0, 0, 0, 0, 0, 0), 8'b1101_0000, "md_abandon");
`ifdef HAZARD_STALL_STATS_EN
        check("stall_cnt_reset", StallCount, 32'd0);
`endif
        step(mk(0, 0, 0, 0, 0, 0, 0), 8'b1101_0000, "md_no_done");
        // randomized run against the reference model
        md_age = 0;
        for (int n = 0; n < 3000; n++) begin
            in_t v;
            logic [7:0] e;
            v = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                   (n == 0) || ($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0);
            if (n == 0) v.rst_n = 1'b0;
            apply(v);
            e = model_out(v);
            check("rand_outs", 32'(outs()), 32'(e));
`ifdef HAZARD_STALL_STATS_EN
            check("rand_stall", StallCount, m_stall);
            check("rand_flush", FlushCount, m_flush);
`endif
            model_adv(v, e);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Stall/flush sequencer for the 5-stage MIPS pipeline. Sits beside the operand forwarding logic in ID/EX.
- Covers the hazards that forwarding cannot resolve:
  - load-use: 1-cycle stall plus bubble;
  - taken branch resolved in EX: flush IF/ID and ID/EX;
  - multi-cycle mul/div in EX: freeze IF/ID/EX, bubble into EX/MEM for MD_LATENCY-1 cycles.
- Drives the pipeline-register write enables and bubble/flush controls.

Parameters:
- MD_LATENCY, 4, total cycles a mul/div instruction occupies EX; legal range 1..16.
- CNT_W, 4, countdown counter width; must satisfy 2^CNT_W >= MD_LATENCY.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  synchronous active-low reset
- IFID_Rs  input  5  rs field of the instruction in ID
- IFID_Rt  input  5  rt field of the instruction in ID
- IFID_UsesRt  input  1  ID instruction reads rt as a source
- IDEX_Rt  input  5  destination rt of the instruction in EX
- IDEX_MemRead  input  1  EX instruction is a load
- IDEX_MulDivStart  input  1  EX instruction is mul/div; stays high while it is held in EX
- BranchTaken  input  1  EX branch/jump resolved taken this cycle
- PCWrite  output  1  PC update enable
- IFIDWrite  output  1  IF/ID register write enable
- IFID_Flush  output  1  IF/ID cleared to NOP on next edge
- IDEXWrite  output  1  ID/EX register write enable
- IDEX_Bubble  output  1  ID/EX control fields zeroed on next edge
- EXMEM_Bubble  output  1  EX/MEM control fields zeroed on next edge
- MulDivBusy  output  1  state is MD_BUSY
- MulDivDone  output  1  1-cycle pulse; mul/div result valid, EX may advance

Behaviour:
- Registered state: RUN, MD_BUSY. Counter cnt[CNT_W-1:0]. All outputs are combinational from state, cnt and inputs.
- Reset: rst_n==0 sampled at a clock edge gives state=RUN, cnt=0. While rst_n==0, outputs are forced to PCWrite=1, IFIDWrite=1, IDEXWrite=1, all other outputs 0. Reset in MD_BUSY abandons the operation with no MulDivDone.
- Default outputs (no event): PCWrite=IFIDWrite=IDEXWrite=1, all others 0.
- Load-use hazard term LU = IDEX_MemRead && IDEX_Rt!=0 && (IDEX_Rt==IFID_Rs || (IFID_UsesRt && IDEX_Rt==IFID_Rt)).
- RUN, priority highest first:
  1. BranchTaken: IFID_Flush=1, IDEX_Bubble=1, PCWrite=1. Overrides LU. State stays RUN.
  2. IDEX_MulDivStart:
     - MD_LATENCY==1: MulDivDone=1, no freeze, state stays RUN.
     - MD_LATENCY>1: PCWrite=IFIDWrite=IDEXWrite=0, EXMEM_Bubble=1 this cycle; next state MD_BUSY, cnt=MD_LATENCY-2.
  3. LU: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1. Exactly 1 stall cycle; LU clears next cycle as the load moves to MEM.
- MD_BUSY:
  - MulDivBusy=1. BranchTaken and LU are ignored, and IDEX_Bubble=0 (EX holds the mul/div).
  - cnt!=0: freeze outputs as in RUN item 2, cnt decrements.
  - cnt==0: default outputs, MulDivDone=1, next state RUN.
  - IDEX_MulDivStart still high here is not a new start.
- Freeze totals: MD_LATENCY-1 freeze cycles per mul/div; MulDivDone lands on cycle MD_LATENCY counted from start.
- Back-to-back mul/div: the next one is detected in RUN on the cycle after MulDivDone.
- Simultaneous BranchTaken and IDEX_MulDivStart cannot occur (the EX instruction is one or the other). If both are asserted, the branch wins and no freeze starts.

Optional Feature:
- Macro HAZARD_STALL_STATS_EN.
- Defined: adds outputs StallCount[31:0] and FlushCount[31:0], both reset to 0.
  - StallCount increments every cycle with PCWrite==0 and rst_n==1.
  - FlushCount increments every cycle with IFID_Flush==1.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour identical.

Test Plan:
- Load-use: IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 -> PCWrite=0, IFIDWrite=0, IDEX_Bubble=1 for that cycle only. Same with IDEX_Rt=0 -> no stall.
- rt-only hazard: IDEX_Rt=9, IFID_Rt=9, IFID_UsesRt=0 -> no stall; with IFID_UsesRt=1 -> 1-cycle stall.
- Branch over load-use: BranchTaken=1 while LU holds -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1.
- Mul/div, MD_LATENCY=4: IDEX_MulDivStart held high -> freeze and EXMEM_Bubble for cycles 1-3, MulDivDone=1 on cycle 4, MulDivBusy high on cycles 2-4.
- During MD_BUSY, BranchTaken=1 and LU asserted -> ignored, IDEX_Bubble=0.
- Reset: rst_n=0 at cycle 2 of mul/div -> next cycle RUN, no MulDivDone. With HAZARD_STALL_STATS_EN defined, StallCount=0 after reset.
